rat_flags_unit: RTL and testbench
=================================

Name: rat_flags_unit

Overview:
Receives the ALU carry/zero outputs and holds the architectural C and Z flags, their interrupt shadow copies, and the interrupt-enable flag I. Synchronises and edge-detects the external interrupt line and raises a pending request to the control unit. Evaluates branch conditions for BRCC/BRCS/BREQ/BRNE/BRN. Sits between the ALU and the control-unit FSM in the RAT CPU.

Parameters:
SYNC_STAGES, 2, number of flops in the INTR_IN synchroniser (legal values 2..4)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
ALU_C  in  1  ALU carry output
ALU_Z  in  1  ALU zero output
FLG_C_LD  in  1  load C from ALU_C
FLG_Z_LD  in  1  load Z from ALU_Z
FLG_C_SET  in  1  SEC: C<=1
FLG_C_CLR  in  1  CLC: C<=0
FLG_RESTORE  in  1  RETID/RETIE: C,Z <= shadow
I_SET  in  1  SEI or RETIE
I_CLR  in  1  CLI or RETID
INT_ACK  in  1  control unit entering interrupt cycle
INTR_IN  in  1  external interrupt, asynchronous
BR_COND  in  3  0 BRN, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRNE, others never
C_FLAG  out  1  architectural carry
Z_FLAG  out  1  architectural zero
SHAD_C  out  1  shadow carry
SHAD_Z  out  1  shadow zero
I_FLAG  out  1  interrupt enable
INT_REQ  out  1  pending interrupt, gated by I_FLAG
BR_TAKE  out  1  branch condition true (combinational)

Behaviour:
- Reset (RST_N low, asynchronous): C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INT_REQ = 0; synchroniser flops, edge register, and pending latch = 0. Outputs remain 0 until the first CLK edge after RST_N deasserts.
- Register update rules, all on CLK rising edge.
- C next-value priority: INT_ACK (hold) > FLG_RESTORE (SHAD_C) > FLG_C_SET (1) > FLG_C_CLR (0) > FLG_C_LD (ALU_C) > hold.
- Z next-value priority: INT_ACK (hold) > FLG_RESTORE (SHAD_Z) > FLG_Z_LD (ALU_Z) > hold.
- Shadow registers: on INT_ACK, SHAD_C <= C_FLAG and SHAD_Z <= Z_FLAG, using pre-edge values. They hold otherwise. FLG_RESTORE does not modify the shadow registers.
- I_FLAG next-value priority: INT_ACK (0) > I_CLR (0) > I_SET (1) > hold. If I_SET and I_CLR are both high, I_CLR wins.
- Interrupt path:
  - INTR_IN passes through SYNC_STAGES flops, then a one-flop edge detector.
  - A 0->1 transition of the synchronised signal sets the pending latch.
  - Latency: a rising edge on INTR_IN makes pending visible SYNC_STAGES+1 edges later.
  - The pending latch clears on INT_ACK. If a new edge and INT_ACK occur in the same cycle, the new edge wins and pending stays 1.
  - Pending is retained while I_FLAG = 0 (not discarded).
  - INT_REQ is registered: INT_REQ <= next_pending & next_I_FLAG. It is therefore 0 in the cycle after INT_ACK.
  - A level held high on INTR_IN produces exactly one request.
- BR_TAKE (purely combinational from the current flags):
  - BRN: 1
  - BRCC: !C
  - BRCS: C
  - BREQ: Z
  - BRNE: !Z
  - codes 5..7: 0
- Reset mid-operation: asynchronous clear of all state, including a pending interrupt and any synchroniser contents. An interrupt edge in flight is lost.
- Width: all datapath signals are 1 bit. No arithmetic is performed.

Decomposition:
- Package rat_pkg holds:
  - enum br_cond_t (BR_N=0, BR_CC=1, BR_CS=2, BR_EQ=3, BR_NE=4), shared with the control-unit decoder
  - constant INT_VECTOR = 8'h3FF[7:0], used by the PC mux and listed here for reference
- One sub-module, rat_intr_sync: the SYNC_STAGES-deep synchroniser plus edge detector, outputting a one-cycle pulse.
- Flag, shadow, and I registers plus the branch decode stay in the top module.

Test Plan:
- Reset released; ALU_C=1, ALU_Z=1, FLG_C_LD=1, FLG_Z_LD=1 for one cycle -> C_FLAG=1, Z_FLAG=1 next edge; BR_COND=1 -> BR_TAKE=0; BR_COND=3 -> BR_TAKE=1.
- C=0 with FLG_C_SET, FLG_C_CLR, and FLG_C_LD (ALU_C=0) all high in the same cycle -> C_FLAG=1 (SET priority); next cycle FLG_C_CLR only -> C_FLAG=0.
- I_SET, then INTR_IN 0->1 held high for 10 cycles -> INT_REQ=1 exactly 3 edges after the edge (SYNC_STAGES=2); INT_ACK with C=1, Z=0 -> next edge: SHAD_C=1, SHAD_Z=0, I_FLAG=0, INT_REQ=0; no second request while INTR_IN stays high.
- After the above, FLG_C_CLR and FLG_Z_LD with ALU_Z=1 -> C=0, Z=1; then FLG_RESTORE and I_SET (RETIE) -> C=1, Z=0, I_FLAG=1.
- I_FLAG=0, INTR_IN pulse -> INT_REQ stays 0; I_SET -> INT_REQ=1 one edge later (pending retained).
- Pending set, RST_N pulsed low mid-cycle -> all outputs 0 immediately (asynchronous), INT_REQ stays 0 after release with I_SET.

Source files
------------

// File: rtl/rat_pkg.sv
// rtl/rat_pkg.sv - shared types and constants for the RAT CPU flag logic
package rat_pkg;

  // Branch condition encoding, shared with the control-unit decoder
  typedef enum logic [2:0] {
    BR_N  = 3'd0,
    BR_CC = 3'd1,
    BR_CS = 3'd2,
    BR_EQ = 3'd3,
    BR_NE = 3'd4
  } br_cond_t;

  // Interrupt vector used by the PC mux; the low eight bits of 10'h3FF
  localparam logic [9:0] INT_VECTOR_FULL = 10'h3FF;
  localparam logic [7:0] INT_VECTOR      = INT_VECTOR_FULL[7:0];

endpackage

// File: rtl/rat_intr_sync.sv
// rtl/rat_intr_sync.sv - interrupt line synchroniser with rising-edge pulse
module rat_intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   edge_q;

  // Shift the asynchronous line into the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Synchroniser flops plus the delayed copy used for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse on a 0->1 transition of the synchronised signal
  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/rat_flags_unit.sv
// rtl/rat_flags_unit.sv - C/Z flags, interrupt shadows, I flag, interrupt request and branch decode
module rat_flags_unit
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ALU_C,
  input  logic       ALU_Z,
  input  logic       FLG_C_LD,
  input  logic       FLG_Z_LD,
  input  logic       FLG_C_SET,
  input  logic       FLG_C_CLR,
  input  logic       FLG_RESTORE,
  input  logic       I_SET,
  input  logic       I_CLR,
  input  logic       INT_ACK,
  input  logic       INTR_IN,
  input  logic [2:0] BR_COND,
  output logic       C_FLAG,
  output logic       Z_FLAG,
  output logic       SHAD_C,
  output logic       SHAD_Z,
  output logic       I_FLAG,
  output logic       INT_REQ,
  output logic       BR_TAKE
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic i_q, i_d;
  logic pend_q, pend_d;
  logic req_q, req_d;
  logic intr_rise;

  rat_intr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_intr_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .async_i(INTR_IN),
    .rise_o (intr_rise)
  );

  // Next-state selection for flags, shadows, I flag and interrupt request
  always_comb begin
    c_d      = c_q;
    z_d      = z_q;
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    i_d      = i_q;

    // Entering the interrupt cycle freezes C/Z and captures them into the shadows
    if (INT_ACK) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end else if (FLG_RESTORE) begin
      c_d = shad_c_q;
      z_d = shad_z_q;
    end else begin
      if (FLG_C_SET) begin
        c_d = 1'b1;
      end else if (FLG_C_CLR) begin
        c_d = 1'b0;
      end else if (FLG_C_LD) begin
        c_d = ALU_C;
      end
      if (FLG_Z_LD) begin
        z_d = ALU_Z;
      end
    end

    // Clear beats set so a simultaneous CLI/SEI leaves interrupts masked
    if (INT_ACK || I_CLR) begin
      i_d = 1'b0;
    end else if (I_SET) begin
      i_d = 1'b1;
    end

    // A fresh edge outranks the acknowledge so it is never dropped
    pend_d = intr_rise | (pend_q & ~INT_ACK);
    req_d  = pend_d & i_d;
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_q      <= 1'b0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
    end
  end

  // Branch condition evaluation from the current architectural flags
  always_comb begin
    BR_TAKE = 1'b0;
    case (br_cond_t'(BR_COND))
      BR_N:    BR_TAKE = 1'b1;
      BR_CC:   BR_TAKE = ~c_q;
      BR_CS:   BR_TAKE = c_q;
      BR_EQ:   BR_TAKE = z_q;
      BR_NE:   BR_TAKE = ~z_q;
      default: BR_TAKE = 1'b0;
    endcase
  end

  assign C_FLAG  = c_q;
  assign Z_FLAG  = z_q;
  assign SHAD_C  = shad_c_q;
  assign SHAD_Z  = shad_z_q;
  assign I_FLAG  = i_q;
  assign INT_REQ = req_q;

endmodule

// File: tb/tb_rat_flags_unit.sv
// tb/tb_rat_flags_unit.sv - directed scoreboard bench for rat_flags_unit
module tb_rat_flags_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ALU_C, ALU_Z, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
  logic       FLG_RESTORE, I_SET, I_CLR, INT_ACK, INTR_IN;
  logic [2:0] BR_COND;
  logic       C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INT_REQ, BR_TAKE;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  rat_flags_unit #(.SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ALU_C      (ALU_C),
    .ALU_Z      (ALU_Z),
    .FLG_C_LD   (FLG_C_LD),
    .FLG_Z_LD   (FLG_Z_LD),
    .FLG_C_SET  (FLG_C_SET),
    .FLG_C_CLR  (FLG_C_CLR),
    .FLG_RESTORE(FLG_RESTORE),
    .I_SET      (I_SET),
    .I_CLR      (I_CLR),
    .INT_ACK    (INT_ACK),
    .INTR_IN    (INTR_IN),
    .BR_COND    (BR_COND),
    .C_FLAG     (C_FLAG),
    .Z_FLAG     (Z_FLAG),
    .SHAD_C     (SHAD_C),
    .SHAD_Z     (SHAD_Z),
    .I_FLAG     (I_FLAG),
    .INT_REQ    (INT_REQ),
    .BR_TAKE    (BR_TAKE)
  );

  always #5 CLK = ~CLK;

  // Vector order: {C, Z, SHAD_C, SHAD_Z, I, INT_REQ, BR_TAKE}
  task automatic compare();
    exp_t       e;
    logic [6:0] obs;
    e   = sb.pop_front();
    obs = {C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INT_REQ, BR_TAKE};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  task automatic idle_inputs();
    ALU_C = 1'b0; ALU_Z = 1'b0; FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0;
    FLG_C_SET = 1'b0; FLG_C_CLR = 1'b0; FLG_RESTORE = 1'b0;
    I_SET = 1'b0; I_CLR = 1'b0; INT_ACK = 1'b0;
  endtask

  // Push the expectation for the coming edge, clock, then compare
  task automatic tick(input string tag, input logic [6:0] v);
    sb.push_back('{tag: tag, v: v});
    @(posedge CLK);
    #1;
    compare();
    idle_inputs();
  endtask

  // Combinational check without a clock edge
  task automatic peek(input string tag, input logic [6:0] v);
    sb.push_back('{tag: tag, v: v});
    #1;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    INTR_IN = 1'b0;
    BR_COND = 3'd0;
    RST_N   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    peek("reset", 7'b000000_1);
    RST_N = 1'b1;
    tick("idle_after_reset", 7'b000000_1);

    ALU_C = 1'b1; ALU_Z = 1'b1; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    tick("ld_cz", 7'b110000_1);
    BR_COND = 3'd1; peek("brcc_c1", 7'b110000_0);
    BR_COND = 3'd3; peek("breq_z1", 7'b110000_1);
    BR_COND = 3'd2; peek("brcs_c1", 7'b110000_1);
    BR_COND = 3'd4; peek("brne_z1", 7'b110000_0);
    BR_COND = 3'd5; peek("br_code5", 7'b110000_0);
    BR_COND = 3'd7; peek("br_code7", 7'b110000_0);
    BR_COND = 3'd0;

    FLG_C_CLR = 1'b1;
    tick("clc", 7'b010000_1);
    FLG_C_SET = 1'b1; FLG_C_CLR = 1'b1; FLG_C_LD = 1'b1; ALU_C = 1'b0;
    tick("c_set_wins", 7'b110000_1);
    FLG_C_CLR = 1'b1;
    tick("clc_only", 7'b010000_1);
    FLG_C_CLR = 1'b1; FLG_C_LD = 1'b1; ALU_C = 1'b1;
    tick("c_clr_beats_ld", 7'b010000_1);
    BR_COND = 3'd1; peek("brcc_c0", 7'b010000_1);
    BR_COND = 3'd0;
    FLG_C_SET = 1'b1; FLG_Z_LD = 1'b1; ALU_Z = 1'b0;
    tick("c1_z0", 7'b100000_1);
    BR_COND = 3'd4; peek("brne_z0", 7'b100000_1);
    BR_COND = 3'd0;

    I_SET = 1'b1;
    tick("sei", 7'b100010_1);
    INTR_IN = 1'b1;
    tick("intr_e1", 7'b100010_1);
    tick("intr_e2", 7'b100010_1);
    tick("intr_e3_req", 7'b100011_1);
    tick("req_holds", 7'b100011_1);
    INT_ACK = 1'b1; FLG_C_CLR = 1'b1; FLG_Z_LD = 1'b1; ALU_Z = 1'b1;
    tick("int_ack", 7'b101000_1);
    for (int k = 0; k < 5; k++) tick("no_second_req", 7'b101000_1);

    FLG_C_CLR = 1'b1; FLG_Z_LD = 1'b1; ALU_Z = 1'b1;
    tick("isr_clobber", 7'b011000_1);
    FLG_RESTORE = 1'b1; I_SET = 1'b1; FLG_C_SET = 1'b1; FLG_Z_LD = 1'b1; ALU_Z = 1'b1;
    tick("retie", 7'b101010_1);
    INTR_IN = 1'b0;
    tick("after_retie_no_req", 7'b101010_1);

    I_CLR = 1'b1;
    tick("cli", 7'b101000_1);
    I_CLR = 1'b1; I_SET = 1'b1;
    tick("clr_beats_set", 7'b101000_1);
    INTR_IN = 1'b1;
    tick("masked_pulse", 7'b101000_1);
    INTR_IN = 1'b0;
    for (int k = 0; k < 4; k++) tick("masked_no_req", 7'b101000_1);
    I_SET = 1'b1;
    tick("pend_retained", 7'b101011_1);

    INTR_IN = 1'b1;
    tick("edge_ack_e1", 7'b101011_1);
    tick("edge_ack_e2", 7'b101011_1);
    INT_ACK = 1'b1;
    tick("edge_ack_same", 7'b101000_1);
    INTR_IN = 1'b0;
    I_SET = 1'b1;
    tick("edge_beats_ack", 7'b101011_1);
    INT_ACK = 1'b1;
    tick("ack_clears", 7'b101000_1);
    I_SET = 1'b1;
    tick("no_spurious_req", 7'b101010_1);

    INTR_IN = 1'b1;
    tick("rst_pulse_e1", 7'b101010_1);
    INTR_IN = 1'b0;
    tick("rst_pulse_e2", 7'b101010_1);
    tick("rst_pulse_e3", 7'b101011_1);
    #3;
    RST_N = 1'b0;
    peek("async_reset", 7'b000000_1);
    #2;
    RST_N = 1'b1;
    I_SET = 1'b1;
    tick("no_req_after_reset", 7'b000010_1);
    tick("still_no_req", 7'b000010_1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
